// File: rtl/mux_pkg.sv
// Shared types and constants for the skid-buffered N:1 operand selector.
package mux_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  localparam int MUX_NUM_IN_MAX = 16;

  // Select width for n inputs; never narrower than one bit.
  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux_n1.sv
// Combinational N:1 select; an out-of-range index falls back to the last input.
module mux_n1 #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 3,
  parameter int SEL_W  = 2
) (
  input  logic [NUM_IN*WIDTH-1:0] data_i,
  input  logic [SEL_W-1:0]        sel_i,
  output logic [WIDTH-1:0]        data_o
);

  logic [NUM_IN-1:0][WIDTH-1:0] in_arr;

  assign in_arr = data_i;

  always_comb begin
    data_o = in_arr[NUM_IN-1];
    for (int k = 0; k < NUM_IN - 1; k++) begin
      if (sel_i == SEL_W'(k)) data_o = in_arr[k];
    end
  end

endmodule

// File: rtl/mux_skid_sel.sv
// N:1 operand selector with a registered valid/ready output stage and one skid entry.
// Optional sticky out-of-range select flag (sel_err_o) built when MUX_SEL_ERR_EN is defined.
module mux_skid_sel
  import mux_pkg::*;
#(
  parameter  int WIDTH  = 32,
  parameter  int NUM_IN = 3,
  localparam int SEL_W  = sel_width(NUM_IN)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    flush_i,
  input  logic [NUM_IN*WIDTH-1:0] data_i,
  input  logic [SEL_W-1:0]        select_i,
  input  logic                    valid_i,
  output logic                    ready_o,
  output logic [WIDTH-1:0]        data_o,
  output logic                    valid_o,
`ifdef MUX_SEL_ERR_EN
  output logic                    sel_err_o,
`endif
  input  logic                    ready_i
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic [WIDTH-1:0] sel_data;
  logic             accept, consume;

  mux_n1 #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN),
    .SEL_W  (SEL_W)
  ) u_mux (
    .data_i (data_i),
    .sel_i  (select_i),
    .data_o (sel_data)
  );

  // ready_o comes straight from the state flop, so it never sees ready_i.
  assign ready_o = (state_q != FULL);
  assign valid_o = (state_q != EMPTY);
  assign data_o  = main_q;

  assign accept  = valid_i & ready_o;
  assign consume = valid_o & ready_i;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d = ONE;
          main_d  = sel_data;
        end
      end
      ONE: begin
        if (accept && consume) begin
          main_d = sel_data;
        end else if (accept) begin
          state_d = FULL;
          skid_d  = sel_data;
        end else if (consume) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (consume) begin
          state_d = ONE;
          main_d  = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Flush overrides everything; data registers simply hold.
    if (flush_i) begin
      state_d = EMPTY;
      main_d  = main_q;
      skid_d  = skid_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

`ifdef MUX_SEL_ERR_EN
  logic sel_err_q, sel_err_d;

  // Sticky until reset; a flushed (dropped) offer does not count as accepted.
  always_comb begin
    sel_err_d = sel_err_q;
    if (accept && !flush_i && (int'(select_i) >= NUM_IN)) sel_err_d = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) sel_err_q <= 1'b0;
    else       sel_err_q <= sel_err_d;
  end

  assign sel_err_o = sel_err_q;
`else
  // No error tracking in this build.
`endif

endmodule

// File: tb/tb_mux_skid_sel.sv
// Randomized bench for mux_skid_sel: three configurations against a queue-based reference.
module tb_mux_skid_sel;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1023:0] din [3];
  logic [3:0]    sel [3];
  logic [2:0]    vin, rin, fl;
  logic [2:0]    vo, ro;
  logic [31:0]   d0;
  logic [7:0]    d1;
  logic [63:0]   d2;
`ifdef MUX_SEL_ERR_EN
  logic [2:0]    eo;
`endif

  mux_skid_sel #(.WIDTH(32), .NUM_IN(3)) u0 (
    .clk_i(clk), .rst_i(rst), .flush_i(fl[0]), .data_i(din[0][95:0]),
    .select_i(sel[0][1:0]), .valid_i(vin[0]), .ready_o(ro[0]), .data_o(d0),
    .valid_o(vo[0]),
`ifdef MUX_SEL_ERR_EN
    .sel_err_o(eo[0]),
`endif
    .ready_i(rin[0]));

  mux_skid_sel #(.WIDTH(8), .NUM_IN(2)) u1 (
    .clk_i(clk), .rst_i(rst), .flush_i(fl[1]), .data_i(din[1][15:0]),
    .select_i(sel[1][0:0]), .valid_i(vin[1]), .ready_o(ro[1]), .data_o(d1),
    .valid_o(vo[1]),
`ifdef MUX_SEL_ERR_EN
    .sel_err_o(eo[1]),
`endif
    .ready_i(rin[1]));

  mux_skid_sel #(.WIDTH(64), .NUM_IN(16)) u2 (
    .clk_i(clk), .rst_i(rst), .flush_i(fl[2]), .data_i(din[2]),
    .select_i(sel[2]), .valid_i(vin[2]), .ready_o(ro[2]), .data_o(d2),
    .valid_o(vo[2]),
`ifdef MUX_SEL_ERR_EN
    .sel_err_o(eo[2]),
`endif
    .ready_i(rin[2]));

  function automatic int n_of(input int i);
    return (i == 0) ? 3 : (i == 1) ? 2 : 16;
  endfunction

  function automatic int w_of(input int i);
    return (i == 0) ? 32 : (i == 1) ? 8 : 64;
  endfunction

  function automatic int sw_of(input int i);
    return (i == 0) ? 2 : (i == 1) ? 1 : 4;
  endfunction

  function automatic logic [63:0] dout(input int i);
    return (i == 0) ? 64'(d0) : (i == 1) ? 64'(d1) : d2;
  endfunction

  // What the selector must deliver for an offer: input[sel], or the last input if sel is too big.
  function automatic logic [63:0] pick(input logic [1023:0] d, input int s, input int n, input int w);
    int            idx;
    logic [1023:0] sh;
    logic [63:0]   m;
    idx = (s < n) ? s : n - 1;
    sh  = d >> (idx * w);
    m   = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    return sh[63:0] & m;
  endfunction

  // Reference: each block is a FIFO of depth two; head is data_o.
  logic [63:0] q [3][$];
  bit          errm [3];

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      for (int i = 0; i < 3; i++) begin
        if (rst) begin
          q[i].delete();
          errm[i] = 1'b0;
        end else begin
          bit acc, con;
          acc = vin[i] && (q[i].size() < 2);
          con = rin[i] && (q[i].size() > 0);
          if (fl[i]) begin
            q[i].delete();
          end else begin
            if (con) void'(q[i].pop_front());
            if (acc) begin
              q[i].push_back(pick(din[i], int'(sel[i]), n_of(i), w_of(i)));
              if (int'(sel[i]) >= n_of(i)) errm[i] = 1'b1;
            end
          end
        end
      end
    end
  end

  int          checks = 0;
  int          errors = 0;
  string       lit_name;
  bit          lit_cv, lit_cr, lit_cd, lit_ce;
  logic        lit_v, lit_r, lit_e;
  logic [63:0] lit_d;
  int          lit_seq  = 0;
  int          lit_seen = 0;

  task automatic cmp(input string nm, input int i, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d actual %0h required %0h at %0t", nm, i, act, exp, $time);
    end
  endtask

  // Single compare process: model checks every cycle, plus any pending hand-computed expectation.
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (rst) begin
          cmp("rst_valid", i, 64'(vo[i]), 64'd0);
          cmp("rst_ready", i, 64'(ro[i]), 64'd1);
          cmp("rst_data", i, dout(i), 64'd0);
`ifdef MUX_SEL_ERR_EN
          cmp("rst_err", i, 64'(eo[i]), 64'd0);
`endif
        end else begin
          cmp("ready", i, 64'(ro[i]), 64'(q[i].size() < 2));
          cmp("valid", i, 64'(vo[i]), 64'(q[i].size() > 0));
          if (q[i].size() > 0) cmp("data", i, dout(i), q[i][0]);
`ifdef MUX_SEL_ERR_EN
          cmp("sel_err", i, 64'(eo[i]), 64'(errm[i]));
`endif
        end
      end
      if (lit_seq != lit_seen) begin
        lit_seen = lit_seq;
        if (lit_cv) cmp({lit_name, "_valid"}, 0, 64'(vo[0]), 64'(lit_v));
        if (lit_cr) cmp({lit_name, "_ready"}, 0, 64'(ro[0]), 64'(lit_r));
        if (lit_cd) cmp({lit_name, "_data"}, 0, dout(0), lit_d);
`ifdef MUX_SEL_ERR_EN
        if (lit_ce) cmp({lit_name, "_err"}, 0, 64'(eo[0]), 64'(lit_e));
`endif
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic set0(input logic v, input int s, input logic r, input logic f);
    vin[0] = v;
    sel[0] = 4'(s);
    rin[0] = r;
    fl[0]  = f;
  endtask

  // Expectation for instance 0 at the next negedge.
  task automatic expect0(input string nm, input logic v, input logic r, input bit cd,
                         input logic [63:0] d, input bit ce, input logic e);
    lit_name = nm;
    lit_cv = 1'b1; lit_v = v;
    lit_cr = 1'b1; lit_r = r;
    lit_cd = cd;   lit_d = d;
    lit_ce = ce;   lit_e = e;
    lit_seq++;
  endtask

  task automatic rand_cycle();
    for (int i = 0; i < 3; i++) begin
      vin[i] = ($urandom_range(0, 9) < 7);
      rin[i] = ($urandom_range(0, 9) < 6);
      fl[i]  = ($urandom_range(0, 39) == 0);
      sel[i] = 4'($urandom_range(0, (1 << sw_of(i)) - 1));
      for (int k = 0; k < 32; k++) din[i][k*32 +: 32] = $urandom();
    end
  endtask

  localparam logic [31:0] A = 32'h1111_aaaa;
  localparam logic [31:0] B = 32'h2222_bbbb;
  localparam logic [31:0] C = 32'h3333_cccc;

  initial begin
    for (int i = 0; i < 3; i++) begin
      din[i] = '0;
      sel[i] = '0;
    end
    vin = '0; rin = '0; fl = '0;
    din[0][95:0] = {C, B, A};

    tick();
    rst = 1'b0;

    // Streaming, one cycle late
    set0(1, 0, 1, 0); expect0("stream_a", 1, 1, 1, 64'(A), 0, 0); tick();
    set0(1, 1, 1, 0); expect0("stream_b", 1, 1, 1, 64'(B), 0, 0); tick();
    set0(1, 2, 1, 0); expect0("stream_c", 1, 1, 1, 64'(C), 0, 0); tick();
    set0(0, 0, 1, 0); expect0("stream_drain", 0, 1, 0, 0, 0, 0); tick();

    // Stall: X=A then Y=B, then a refused offer of C
    set0(1, 0, 0, 0); expect0("stall_one", 1, 1, 1, 64'(A), 0, 0); tick();
    set0(1, 1, 0, 0); expect0("stall_full", 1, 0, 1, 64'(A), 0, 0); tick();
    set0(1, 2, 0, 0); expect0("stall_hold", 1, 0, 1, 64'(A), 0, 0); tick();
    set0(0, 0, 1, 0); expect0("stall_y", 1, 1, 1, 64'(B), 0, 0); tick();
    set0(0, 0, 1, 0); expect0("stall_empty", 0, 1, 0, 0, 0, 0); tick();

    // Out of range select -> last input; error flag survives flush
    set0(1, 3, 0, 0); expect0("oor_last", 1, 1, 1, 64'(C), 1, 1); tick();
    set0(0, 0, 0, 1); expect0("oor_flush", 0, 1, 0, 0, 1, 1); tick();

    // Flush in FULL with a same-cycle offer
    set0(1, 0, 0, 0); expect0("ff_one", 1, 1, 1, 64'(A), 0, 0); tick();
    set0(1, 1, 0, 0); expect0("ff_full", 1, 0, 1, 64'(A), 0, 0); tick();
    set0(1, 2, 1, 1); expect0("ff_flush", 0, 1, 0, 0, 0, 0); tick();
    set0(0, 0, 1, 0); expect0("ff_dropped", 0, 1, 0, 0, 0, 0); tick();

    // Random traffic on all three configurations
    repeat (1500) begin
      rand_cycle();
      tick();
    end

    // Asynchronous reset mid-cycle, checked before any further clock edge
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    #1 rst = 1'b0;

    repeat (1500) begin
      rand_cycle();
      tick();
    end

    vin = '0; fl = '0;
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
